// File: rtl/stack_loop_fifo_if.sv
// MAC-side Avalon-ST bundle: the TX beat stream into the loop and the RX beat stream back out.
// The master modport is the DMA side; the slave modport is the loopback.
interface stack_loop_fifo_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned EMPTY_W = 3
);
  logic               tx_valid;
  logic               tx_ready;
  logic               tx_sop;
  logic               tx_eop;
  logic               tx_error;
  logic [DATA_W-1:0]  tx_data;
  logic [EMPTY_W-1:0] tx_empty;

  logic               rx_valid;
  logic               rx_ready;
  logic               rx_sop;
  logic               rx_eop;
  logic               rx_error;
  logic [DATA_W-1:0]  rx_data;
  logic [EMPTY_W-1:0] rx_empty;

  modport master (
    output tx_valid, tx_sop, tx_eop, tx_error, tx_data, tx_empty, rx_ready,
    input  tx_ready, rx_valid, rx_sop, rx_eop, rx_error, rx_data, rx_empty
  );

  modport slave (
    input  tx_valid, tx_sop, tx_eop, tx_error, tx_data, tx_empty, rx_ready,
    output tx_ready, rx_valid, rx_sop, rx_eop, rx_error, rx_data, rx_empty
  );
endinterface

// File: rtl/stack_loop_fifo.sv
// MAC-side loopback: TX beats are buffered in a FIFO and replayed on RX, in either cut-through
// or store-and-forward mode, with a sticky flag for TX framing violations.
module stack_loop_fifo #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = 3,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned STORE_FWD = 0
) (
  input  logic                   clockMac,
  input  logic                   resetNMac,
  stack_loop_fifo_if.slave       mac,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   proto_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic               error;
    logic [EMPTY_W-1:0] empty;
  } entry_t;

  typedef enum logic {FR_IDLE, FR_PKT}    frame_e;
  typedef enum logic {DR_HOLD, DR_DRAIN}  drain_e;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               perr_q, perr_d;
  logic               rst_done_q;
  frame_e             frame_q, frame_d;
  drain_e             drain_q, drain_d;

  logic               full_c;
  logic               tx_ready_c;
  logic               rx_valid_c;
  logic               wr_en_c;
  logic               rd_en_c;
  entry_t             wr_ent_c;
  entry_t             rd_ent_c;

  // Handshake qualifiers: derived only from registered state, never from the opposite side.
  always_comb begin
    full_c     = (level_q == LVL_W'(DEPTH));
    tx_ready_c = rst_done_q && !full_c;
    if (STORE_FWD != 0) begin
      // A full FIFO with no complete packet releases an oversize packet; it then drains to eop.
      rx_valid_c = (level_q != '0) &&
                   ((pkt_cnt_q != '0) || full_c || (drain_q == DR_DRAIN));
    end else begin
      rx_valid_c = (level_q != '0);
    end
    wr_en_c        = mac.tx_valid && tx_ready_c;
    rd_en_c        = rx_valid_c && mac.rx_ready;
    rd_ent_c       = mem_q[rd_ptr_q];
    wr_ent_c.data  = mac.tx_data;
    wr_ent_c.sop   = mac.tx_sop;
    wr_ent_c.eop   = mac.tx_eop;
    wr_ent_c.error = mac.tx_error;
    wr_ent_c.empty = mac.tx_empty;
  end

  // Next-state: pointers, occupancy, packet count, framing tracker and release tracker.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    perr_d    = perr_q;
    frame_d   = frame_q;
    drain_d   = drain_q;

    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({wr_en_c, rd_en_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    unique case ({wr_en_c && mac.tx_eop, rd_en_c && rd_ent_c.eop})
      2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    if (wr_en_c) begin
      if ((frame_q == FR_IDLE && !mac.tx_sop) || (frame_q == FR_PKT && mac.tx_sop)) begin
        perr_d = 1'b1;
      end
      if (mac.tx_eop)      frame_d = FR_IDLE;
      else if (mac.tx_sop) frame_d = FR_PKT;
    end

    if (rd_en_c) drain_d = rd_ent_c.eop ? DR_HOLD : DR_DRAIN;
  end

  always_ff @(posedge clockMac or negedge resetNMac) begin
    if (!resetNMac) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      perr_q     <= 1'b0;
      rst_done_q <= 1'b0;
      frame_q    <= FR_IDLE;
      drain_q    <= DR_HOLD;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      perr_q     <= perr_d;
      rst_done_q <= 1'b1;
      frame_q    <= frame_d;
      drain_q    <= drain_d;
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clockMac) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= wr_ent_c;
  end

  assign mac.tx_ready = tx_ready_c;
  assign mac.rx_valid = rx_valid_c;
  assign mac.rx_data  = rd_ent_c.data;
  assign mac.rx_sop   = rd_ent_c.sop;
  assign mac.rx_eop   = rd_ent_c.eop;
  assign mac.rx_error = rd_ent_c.error;
  assign mac.rx_empty = rd_ent_c.empty;
  assign level        = level_q;
  assign pkt_count    = pkt_cnt_q;
  assign proto_err    = perr_q;

endmodule

// File: tb/tb_stack_loop_fifo.sv
// Randomized bench: three loop configurations (cut-through/16, store-forward/16, store-forward/4)
// compared every cycle against a queue-based model of the loopback.
module tb_stack_loop_fifo;

  typedef logic [69:0] beat_t;  // {data[63:0], sop, eop, error, empty[2:0]}

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  stack_loop_fifo_if #(.DATA_W(64), .EMPTY_W(3)) if0 ();
  stack_loop_fifo_if #(.DATA_W(64), .EMPTY_W(3)) if1 ();
  stack_loop_fifo_if #(.DATA_W(64), .EMPTY_W(3)) if2 ();

  logic [4:0] lvl0, pc0, lvl1, pc1;
  logic [2:0] lvl2, pc2;
  logic       pe0, pe1, pe2;

  stack_loop_fifo #(.DATA_W(64), .EMPTY_W(3), .DEPTH(16), .STORE_FWD(0)) u_ct16 (
    .clockMac(clk), .resetNMac(rst_n), .mac(if0),
    .level(lvl0), .pkt_count(pc0), .proto_err(pe0));
  stack_loop_fifo #(.DATA_W(64), .EMPTY_W(3), .DEPTH(16), .STORE_FWD(1)) u_sf16 (
    .clockMac(clk), .resetNMac(rst_n), .mac(if1),
    .level(lvl1), .pkt_count(pc1), .proto_err(pe1));
  stack_loop_fifo #(.DATA_W(64), .EMPTY_W(3), .DEPTH(4), .STORE_FWD(1)) u_sf4 (
    .clockMac(clk), .resetNMac(rst_n), .mac(if2),
    .level(lvl2), .pkt_count(pc2), .proto_err(pe2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input beat_t got, input beat_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one queue of beats per loop plus the packet-level status.
  beat_t q0[$], q1[$], q2[$];
  bit    in_pkt_m [3];
  bit    perr_m   [3];
  bit    mid_m    [3];   // a packet has been partly read out
  bit    rst_done_m;

  beat_t pend   [3];
  bit    pend_v [3];
  int    gpos   [3];
  int    glen   [3];

  function automatic int depth_of(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic bit sf_of(input int i);
    return i != 0;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t qat(input int i, input int k);
    case (i)
      0:       return q0[k];
      1:       return q1[k];
      default: return q2[k];
    endcase
  endfunction

  task automatic qpush(input int i, input beat_t b);
    case (i)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic qpop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  function automatic int qeops(input int i);
    int n = 0;
    for (int k = 0; k < qsize(i); k++) begin
      beat_t b = qat(i, k);
      if (b[4]) n++;
    end
    return n;
  endfunction

  function automatic bit exp_tx_ready(input int i);
    return rst_done_m && (qsize(i) < depth_of(i));
  endfunction

  function automatic bit exp_rx_valid(input int i);
    if (qsize(i) == 0) return 1'b0;
    if (!sf_of(i))     return 1'b1;
    return (qeops(i) > 0) || (qsize(i) == depth_of(i)) || mid_m[i];
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      in_pkt_m[i] = 1'b0;
      perr_m[i]   = 1'b0;
      mid_m[i]    = 1'b0;
      pend_v[i]   = 1'b0;
      gpos[i]     = 0;
      glen[i]     = 1;
    end
    rst_done_m = 1'b0;
  endtask

  task automatic drv(input int i, input bit tv, input beat_t b, input bit rr);
    case (i)
      0: begin
        if0.tx_valid = tv; if0.tx_data = b[69:6]; if0.tx_sop = b[5]; if0.tx_eop = b[4];
        if0.tx_error = b[3]; if0.tx_empty = b[2:0]; if0.rx_ready = rr;
      end
      1: begin
        if1.tx_valid = tv; if1.tx_data = b[69:6]; if1.tx_sop = b[5]; if1.tx_eop = b[4];
        if1.tx_error = b[3]; if1.tx_empty = b[2:0]; if1.rx_ready = rr;
      end
      default: begin
        if2.tx_valid = tv; if2.tx_data = b[69:6]; if2.tx_sop = b[5]; if2.tx_eop = b[4];
        if2.tx_error = b[3]; if2.tx_empty = b[2:0]; if2.rx_ready = rr;
      end
    endcase
  endtask

  task automatic get_obs(input int i, output bit tr, output bit rv, output beat_t rb,
                         output int lvl, output int pc, output bit pe);
    case (i)
      0: begin
        tr = if0.tx_ready; rv = if0.rx_valid; lvl = 32'(lvl0); pc = 32'(pc0); pe = pe0;
        rb = {if0.rx_data, if0.rx_sop, if0.rx_eop, if0.rx_error, if0.rx_empty};
      end
      1: begin
        tr = if1.tx_ready; rv = if1.rx_valid; lvl = 32'(lvl1); pc = 32'(pc1); pe = pe1;
        rb = {if1.rx_data, if1.rx_sop, if1.rx_eop, if1.rx_error, if1.rx_empty};
      end
      default: begin
        tr = if2.tx_ready; rv = if2.rx_valid; lvl = 32'(lvl2); pc = 32'(pc2); pe = pe2;
        rb = {if2.rx_data, if2.rx_sop, if2.rx_eop, if2.rx_error, if2.rx_empty};
      end
    endcase
  endtask

  task automatic check_outputs(input int i);
    bit tr, rv, pe;
    beat_t rb;
    int lvl, pc;
    get_obs(i, tr, rv, rb, lvl, pc, pe);
    chk($sformatf("i%0d tx_ready", i),  70'(tr),  70'(exp_tx_ready(i)));
    chk($sformatf("i%0d rx_valid", i),  70'(rv),  70'(exp_rx_valid(i)));
    chk($sformatf("i%0d level", i),     70'(lvl), 70'(qsize(i)));
    chk($sformatf("i%0d pkt_count", i), 70'(pc),  70'(qeops(i)));
    chk($sformatf("i%0d proto_err", i), 70'(pe),  70'(perr_m[i]));
    if (rv && exp_rx_valid(i)) chk($sformatf("i%0d rx_beat", i), rb, qat(i, 0));
  endtask

  task automatic check_reset_state(input string tag);
    bit tr, rv, pe;
    beat_t rb;
    int lvl, pc;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, tr, rv, rb, lvl, pc, pe);
      chk($sformatf("%s i%0d tx_ready", tag, i),  70'(tr),  70'(0));
      chk($sformatf("%s i%0d rx_valid", tag, i),  70'(rv),  70'(0));
      chk($sformatf("%s i%0d level", tag, i),     70'(lvl), 70'(0));
      chk($sformatf("%s i%0d pkt_count", tag, i), 70'(pc),  70'(0));
      chk($sformatf("%s i%0d proto_err", tag, i), 70'(pe),  70'(0));
    end
  endtask

  // Legal packets of 1..12 beats; viol_pct flips sop on a beat to create framing errors.
  function automatic beat_t mk_beat(input int i, input int viol_pct);
    bit sop, eop;
    if (gpos[i] == 0) glen[i] = $urandom_range(1, 12);
    sop = (gpos[i] == 0);
    eop = (gpos[i] == glen[i] - 1);
    if ($urandom_range(0, 99) < viol_pct) sop = !sop;
    gpos[i] = eop ? 0 : gpos[i] + 1;
    return {$urandom, $urandom, sop, eop, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
  endfunction

  task automatic run_cycles(input int n, input int txp, input int rxp, input int viol_pct);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_outputs(i);
      for (int i = 0; i < 3; i++) begin
        bit rr, ew, er;
        beat_t b;
        if (!pend_v[i] && $urandom_range(0, 99) < txp) begin
          pend[i]   = mk_beat(i, viol_pct);
          pend_v[i] = 1'b1;
        end
        rr = ($urandom_range(0, 99) < rxp);
        ew = pend_v[i] && exp_tx_ready(i);
        er = rr && exp_rx_valid(i);
        drv(i, pend_v[i], pend[i], rr);
        if (er) begin
          b = qat(i, 0);
          mid_m[i] = !b[4];
          qpop(i);
        end
        if (ew) begin
          b = pend[i];
          if (in_pkt_m[i] ? b[5] : !b[5]) perr_m[i] = 1'b1;
          if (b[4])      in_pkt_m[i] = 1'b0;
          else if (b[5]) in_pkt_m[i] = 1'b1;
          qpush(i, b);
          pend_v[i] = 1'b0;
        end
      end
      rst_done_m = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) drv(i, 1'b0, '0, 1'b0);
    #3;
    check_reset_state("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("post_release");
    rst_done_m = 1'b1;

    run_cycles(300, 70, 60, 0);   // mixed legal traffic
    run_cycles(30, 100, 0, 0);    // fill against a stalled sink
    run_cycles(60, 100, 100, 0);  // drain and full-rate streaming
    run_cycles(200, 60, 30, 0);   // heavy backpressure
    run_cycles(8, 100, 0, 0);     // build occupancy before reset

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    for (int i = 0; i < 3; i++) drv(i, 1'b0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("re_release");
    rst_done_m = 1'b1;

    run_cycles(300, 70, 60, 10);  // traffic with framing violations

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
